// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 size/sign codes and FSM states.
// Latency: none (declarations only).
// Backpressure: none.
package lsu_pkg;

  // funct3 size/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access legality check, store lane formatting and load lane extraction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: is_load/is_store/funct3/addr_lo/store_data describe the incoming request
//        (legal, wstrb, wdata); ld_funct3/ld_addr_lo/rdata describe the outstanding
//        load (ld_data).
import lsu_pkg::*;

module lsu_align (
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic       f3_ok;
  logic       align_ok;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  // Legality: unsigned variants exist only for loads; halfwords need even
  // addresses and words need word-aligned addresses.
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (funct3)
      F3_B:  begin f3_ok = 1'b1;    align_ok = 1'b1;              end
      F3_H:  begin f3_ok = 1'b1;    align_ok = ~addr_lo[0];       end
      F3_W:  begin f3_ok = 1'b1;    align_ok = (addr_lo == 2'b00); end
      F3_BU: begin f3_ok = is_load; align_ok = 1'b1;              end
      F3_HU: begin f3_ok = is_load; align_ok = ~addr_lo[0];       end
      default: begin f3_ok = 1'b0;  align_ok = 1'b0;              end
    endcase
    legal = (is_load ^ is_store) & f3_ok & align_ok;
  end

  // Store data is replicated across lanes so the strobe alone selects the target bytes.
  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack memory transaction per access, aligned/extended load result.
// Latency: start at cycle 0 -> mem_req from cycle 1; ack at cycle k -> done at cycle k+1.
// Backpressure: start ignored while busy; memory stalls by withholding mem_ack (unbounded).
// Ports: clk/rst; request (start, is_load, is_store, funct3, addr, store_data, rd_in);
//        response (busy, done, fault, load_data, rd_out); memory (mem_req, mem_we,
//        mem_addr, mem_wstrb, mem_wdata, mem_ack, mem_rdata).
import lsu_pkg::*;

module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] load_data,
  output logic [4:0]      rd_out,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic        lat_is_load;

  logic        legal;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;
  logic [31:0] ext_data;

  lsu_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .legal      (legal),
    .wstrb      (fmt_wstrb),
    .wdata      (fmt_wdata),
    .ld_funct3  (lat_funct3),
    .ld_addr_lo (lat_addr_lo),
    .rdata      (mem_rdata),
    .ld_data    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      load_data   <= '0;
      rd_out      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
      lat_funct3  <= '0;
      lat_addr_lo <= '0;
      lat_is_load <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          // A start with neither load nor store is not an access at all.
          if (start && (is_load || is_store)) begin
            busy   <= 1'b1;
            rd_out <= rd_in;
            if (legal) begin
              state       <= REQ;
              lat_funct3  <= funct3;
              lat_addr_lo <= addr[1:0];
              lat_is_load <= is_load;
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= {addr[XLEN-1:2], 2'b00};
              mem_wstrb   <= is_store ? fmt_wstrb : 4'b0000;
              mem_wdata   <= fmt_wdata;
            end else begin
              // Illegal access completes immediately without touching memory.
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (lat_is_load) begin
              load_data <= ext_data;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays the memory and chooses when to acknowledge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .rd_out     (rd_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request; start is dropped after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd_in = rd;
    tick();
    start = 1'b0;
  endtask

  // Load with immediate ack: request cycle 1, ack sampled at the edge into cycle 2 (DONE).
  task automatic quick_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [4:0] rd);
    mem_rdata = rdata;
    issue(1'b1, 1'b0, f3, a, 32'd0, rd);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);

    // LW with three wait cycles: mem_req held cycles 1..4, ack in cycle 4, done cycle 5
    mem_rdata = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd5);
    for (int i = 1; i <= 3; i++) begin
      check("lw_wait_req", {31'd0, mem_req}, 32'd1);
      check("lw_wait_addr", mem_addr, 32'h0000_0100);
      check("lw_wait_done", {31'd0, done}, 32'd0);
      tick();
    end
    check("lw_we", {31'd0, mem_we}, 32'd0);
    check("lw_busy", {31'd0, busy}, 32'd1);
    check("lw_req_c4", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lw_done", {31'd0, done}, 32'd1);
    check("lw_fault", {31'd0, fault}, 32'd0);
    check("lw_req_drop", {31'd0, mem_req}, 32'd0);
    check("lw_data", load_data, 32'hDEADBEEF);
    check("lw_rd_out", {27'd0, rd_out}, 32'd5);
    check("lw_busy_done", {31'd0, busy}, 32'd1);
    tick();
    check("lw_done_once", {31'd0, done}, 32'd0);
    check("lw_idle_busy", {31'd0, busy}, 32'd0);

    // LB / LBU / LH / LHU lane extraction
    quick_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 5'd6);
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_data", load_data, 32'hFFFF_FF80);
    tick();
    quick_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 5'd7);
    check("lbu_data", load_data, 32'h0000_0080);
    check("lbu_rd_out", {27'd0, rd_out}, 32'd7);
    tick();
    quick_load(3'b001, 32'h0000_0102, 32'h80FF_0000, 5'd8);
    check("lh_data", load_data, 32'hFFFF_80FF);
    tick();
    quick_load(3'b101, 32'h0000_0102, 32'h80FF_0000, 5'd9);
    check("lhu_data", load_data, 32'h0000_80FF);
    tick();

    // SB then SH
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h0000_00A5, 5'd0);
    check("sb_req", {31'd0, mem_req}, 32'd1);
    check("sb_we", {31'd0, mem_we}, 32'd1);
    check("sb_addr", mem_addr, 32'h0000_0200);
    check("sb_wstrb", {28'd0, mem_wstrb}, 32'h4);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_done", {31'd0, done}, 32'd1);
    check("sb_load_data_kept", load_data, 32'h0000_80FF);
    tick();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0);
    check("sh_we", {31'd0, mem_we}, 32'd1);
    check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_done", {31'd0, done}, 32'd1);
    tick();

    // SW full word
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 5'd0);
    check("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Misaligned LW: fault in cycle start+1, no request, load_data kept
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 5'd3);
    check("mis_done", {31'd0, done}, 32'd1);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_busy", {31'd0, busy}, 32'd1);
    check("mis_load_data_kept", load_data, 32'h0000_80FF);
    tick();
    check("mis_done_clear", {31'd0, done}, 32'd0);
    check("mis_fault_clear", {31'd0, fault}, 32'd0);
    check("mis_idle_busy", {31'd0, busy}, 32'd0);

    // Store with unsigned funct3 is illegal
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'd0, 5'd0);
    check("sbu_fault", {31'd0, fault}, 32'd1);
    check("sbu_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Both is_load and is_store set is illegal
    issue(1'b1, 1'b1, 3'b000, 32'h0000_0200, 32'd0, 5'd0);
    check("both_fault", {31'd0, fault}, 32'd1);
    tick();

    // Neither is_load nor is_store: ignored
    issue(1'b0, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd0);
    check("none_busy", {31'd0, busy}, 32'd0);
    check("none_done", {31'd0, done}, 32'd0);
    check("none_req", {31'd0, mem_req}, 32'd0);

    // Stray ack in IDLE
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_done", {31'd0, done}, 32'd0);
    check("stray_req", {31'd0, mem_req}, 32'd0);

    // Reset in the middle of a pending LW
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd4);
    tick();
    check("rstreq_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstreq_req", {31'd0, mem_req}, 32'd0);
    check("rstreq_busy", {31'd0, busy}, 32'd0);
    check("rstreq_done", {31'd0, done}, 32'd0);
    check("rstreq_load_data", load_data, 32'd0);
    mem_rdata = 32'h1111_2222;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late_ack_done", {31'd0, done}, 32'd0);
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    check("late_ack_data", load_data, 32'd0);

    // Back-to-back with start held high
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0300; rd_in = 5'd7; mem_rdata = 32'h0BAD_F00D;
    tick();
    check("b2b_req1", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_data1", load_data, 32'h0BAD_F00D);
    tick();
    check("b2b_gap_req", {31'd0, mem_req}, 32'd0);
    check("b2b_gap_done", {31'd0, done}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    check("b2b_req2", {31'd0, mem_req}, 32'd1);
    check("b2b_req2_done", {31'd0, done}, 32'd0);
    mem_rdata = 32'h0000_0042;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_data2", load_data, 32'h0000_0042);
    tick();
    check("b2b_done2_once", {31'd0, done}, 32'd0);
    check("b2b_final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute→memory stage, directly downstream of the ALU.
- Takes the ALU result as the effective address, with rs2 as store data.
- Runs one request/acknowledge transaction per access on the word-wide data-memory port. Returns aligned, sign- or zero-extended load data with the destination register tag for writeback.
- Detects misaligned and illegal accesses and never issues them to memory.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  access request from the execute stage; sampled only while busy=0
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  XLEN  effective address (ALU result)
- store_data  input  XLEN  rs2 value
- rd_in  input  5  destination register tag
- busy  output  1  access in progress; start is ignored while high
- done  output  1  one-cycle completion pulse
- fault  output  1  valid with done; access aborted
- load_data  output  XLEN  extended load result; valid with done
- rd_out  output  5  tag of the completed access; valid with done
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  XLEN  word address {addr[31:2], 2'b00}
- mem_wstrb  output  4  byte-lane write enables
- mem_wdata  output  XLEN  lane-replicated store data
- mem_ack  input  1  memory acknowledge; read data valid in the same cycle
- mem_rdata  input  XLEN  read word

Behaviour:
- Reset values: busy, done, fault, mem_req and mem_we are 0. load_data, rd_out, mem_addr, mem_wstrb and mem_wdata are 0. State is IDLE.
- States: IDLE, REQ, DONE.
- IDLE → REQ: start=1 with a legal access. On this edge the unit latches addr, funct3, is_load, rd_in and the lane-formatted store data. busy=1 and mem_req=1 from the next cycle.
- Legal access:
  - exactly one of is_load/is_store is set;
  - funct3 is legal for the type: stores allow 000/001/010 only, loads allow all five listed codes;
  - alignment holds: H/HU needs addr[0]=0, W needs addr[1:0]=00.
- start with both is_load and is_store at 0 is ignored (no response).
- Any other illegal start (both set, illegal funct3, misaligned) goes IDLE → DONE directly:
  - fault=1, no mem_req ever issued;
  - done and fault pulse in cycle start+1;
  - load_data is unchanged.
- REQ: mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until mem_ack=1 is sampled. Wait length is unbounded.
- On the mem_ack edge:
  - mem_req drops in the following cycle;
  - for a load, the selected lane of mem_rdata is extended and registered into load_data;
  - the state goes to DONE.
- DONE: done=1 for exactly one cycle, rd_out holds the latched tag, and busy stays 1. The next cycle returns to IDLE with busy=0.
- A start pulsed in the DONE cycle is ignored.
- Latency:
  - start at cycle 0 → mem_req from cycle 1;
  - ack at cycle k → done at cycle k+1;
  - minimum is ack at cycle 1 → done at cycle 2.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], wdata = 4 copies of byte[7:0];
  - H: wstrb = 0011 << addr[1:0], wdata = 2 copies of half[15:0];
  - W: wstrb = 1111, wdata = store_data.
- Load extraction: byte lane addr[1:0] or half lane addr[1]. B/H sign-extend; BU/HU zero-extend.
- load_data is left unchanged by stores and faults.
- mem_ack while not in REQ is ignored.
- rst in any state: the next edge forces IDLE with all outputs at reset values. The issuing memory is responsible for discarding a pending request; a late ack after reset is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding (IDLE, REQ, DONE).
- One combinational sub-module, lsu_align, covering:
  - legality/misalignment check;
  - strobe and wdata lane replication;
  - load lane select and extension.
- The FSM and registers stay in lsu.

Test Plan:
- LW: addr=0x100, mem_rdata=0xDEADBEEF, ack after 3 wait cycles → mem_req held 4 cycles with mem_addr=0x100; done one cycle later; load_data=0xDEADBEEF; rd_out=rd_in; fault=0.
- LB/LBU: addr=0x103, rdata=0x80FF_0000 → LB load_data=0xFFFFFF80; LBU → 0x00000080.
- SB then SH:
  - SB addr=0x202, store_data=0x000000A5 → mem_we=1, wstrb=0100, wdata=0xA5A5A5A5;
  - SH addr=0x202, store_data=0x1234 → wstrb=1100, wdata=0x12341234.
- Misaligned LW at addr=0x101 → no mem_req; done=1 and fault=1 in cycle start+1; load_data unchanged.
- Stray mem_ack in IDLE → no state change. Then start an LW, wait 2 cycles and assert rst while mem_req=1 → next cycle mem_req=0, busy=0, done=0. A subsequent ack is ignored.
- Back-to-back:
  - start held high continuously is accepted only when busy=0;
  - the second access's mem_req appears 2 cycles after the first done;
  - done never pulses twice for one access.
